// File: rtl/uart_tx_mmio_if.sv
// CPU-side bus view of the UART transmitter: address/data/strobe from the core,
// STATUS readback and bus-drive enable from the block.
interface uart_tx_mmio_if;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic        read_en;
  logic [7:0]  data_out;
  logic        data_oe;

  modport master (
    output address,
    output data_in,
    output read_en,
    input  data_out,
    input  data_oe
  );

  modport slave (
    input  address,
    input  data_in,
    input  read_en,
    output data_out,
    output data_oe
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 transmitter: CPU stores to TXDATA feed a small FIFO that a
// serializer drains onto tx; STATUS reports overflow/busy/empty/full.
module uart_tx_mmio #(
  parameter logic [15:0] BASE_ADDR    = 16'hF000,
  parameter int          DEPTH        = 4,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic           ph1,
  input  logic           resetb,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           irq_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   STATUS_ADDR = BASE_ADDR + 16'd1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;
  logic          wr_s, rd_s, full_s, empty_s, push_s, pop_s, baud_end_s;
  logic [7:0]    status_s;

  // Bus decode, status byte and readback drive.
  always_comb begin
    wr_s       = !bus.read_en && (bus.address == BASE_ADDR);
    rd_s       = bus.read_en && (bus.address == STATUS_ADDR);
    full_s     = (count_q == FULL_CNT);
    empty_s    = (count_q == {CW{1'b0}});
    push_s     = wr_s && !full_s;
    baud_end_s = (baud_q == BAUD_LAST);
    status_s   = {ovf_q, 4'b0000, (state_q != S_IDLE), empty_s, full_s};
    bus.data_oe  = rd_s;
    bus.data_out = rd_s ? status_s : 8'h00;
  end

  // Serializer FSM; a pop happens only when a new frame is loaded.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = {BW{1'b0}};
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rptr_q];
          state_d = S_START;
          tx_d    = 1'b0;
        end else begin
          tx_d    = 1'b1;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          baud_d  = {BW{1'b0}};
          bit_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_d = {BW{1'b0}};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_end_s) begin
          baud_d = {BW{1'b0}};
          // Back-to-back frames: load the next byte with no idle gap.
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = {BW{1'b0}};
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping, sticky overflow (set wins over clear) and interrupt.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (push_s && (wptr_q == AW'(i))) ? bus.data_in : mem_q[i];
    end
    wptr_d = push_s ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d = pop_s  ? (rptr_q + AW'(1)) : rptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = (wr_s && full_s) ? 1'b1 : (rd_s ? 1'b0 : ovf_q);
    irq_d = (count_d == {CW{1'b0}}) && (state_d == S_IDLE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge ph1) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      baud_q  <= {BW{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
    end
  end

  assign tx        = tx_q;
  assign irq_empty = irq_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomized bench for uart_tx_mmio: a frame-timing model (byte queue plus
// cycles-into-frame) predicts tx, irq_empty and STATUS every cycle.
module tb_uart_tx_mmio;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [15:0] BASE  = 16'hF000;

  logic ph1 = 1'b0;
  logic resetb = 1'b0;
  logic tx, irq_empty;
  int   total = 0;
  int   bad = 0;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .ph1(ph1), .resetb(resetb), .bus(bus), .tx(tx), .irq_empty(irq_empty)
  );

  always #5 ph1 = ~ph1;

  // Model: bytes waiting in the FIFO, byte on the line, cycles since its start edge.
  logic [7:0] mq[$];
  logic [7:0] m_byte = 8'h00;
  bit         m_act = 1'b0;
  bit         m_ov = 1'b0;
  bit         m_valid = 1'b0;
  int         m_fc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    if (!m_act) return 1'b1;
    if (m_fc < CPB) return 1'b0;
    if (m_fc < 9 * CPB) return m_byte[(m_fc - CPB) / CPB];
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_status();
    return {m_ov, 4'b0000, m_act, (mq.size() == 0), (mq.size() == DEPTH)};
  endfunction

  task automatic model_step();
    bit wr, rd, was_full;
    if (!resetb) begin
      mq.delete();
      m_act = 1'b0; m_fc = 0; m_ov = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      wr = !bus.read_en && (bus.address == BASE);
      rd = bus.read_en && (bus.address == BASE + 16'd1);
      was_full = (mq.size() == DEPTH);
      if (m_act) begin
        m_fc++;
        if (m_fc == 10 * CPB) m_act = 1'b0;
      end
      if (!m_act && mq.size() != 0) begin
        m_byte = mq.pop_front();
        m_act = 1'b1;
        m_fc = 0;
      end
      if (wr) begin
        if (was_full) m_ov = 1'b1;
        else mq.push_back(bus.data_in);
      end else if (rd) begin
        m_ov = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge ph1);
    model_step();
  end

  // Per-cycle comparison, away from the active edge.
  initial forever begin
    logic rd_now;
    @(negedge ph1);
    if (m_valid) begin
      rd_now = bus.read_en && (bus.address == BASE + 16'd1);
      chk("tx", tx, exp_tx());
      chk("irq_empty", irq_empty, (mq.size() == 0) && !m_act);
      chk("data_oe", bus.data_oe, rd_now);
      chk("data_out", bus.data_out, rd_now ? exp_status() : 8'h00);
    end
  end

  task automatic step(input logic [15:0] a, input logic [7:0] d, input logic ren);
    bus.address = a; bus.data_in = d; bus.read_en = ren;
    @(posedge ph1); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'h0000, 8'h00, 1'b1);
  endtask

  task automatic probe(input logic [15:0] a, input logic [7:0] d, input logic ren,
                       output logic [7:0] dout, output logic oe);
    bus.address = a; bus.data_in = d; bus.read_en = ren;
    @(negedge ph1);
    dout = bus.data_out;
    oe   = bus.data_oe;
    @(posedge ph1); #1;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (!(mq.size() == 0 && !m_act) && n < limit) begin
      idle(1);
      n++;
    end
    chk("drain_bound", (mq.size() == 0 && !m_act), 1'b1);
    idle(1);
    chk("drain_irq", irq_empty, 1'b1);
  endtask

  initial begin
    logic [7:0] st, x, y, z;
    logic       oe;
    logic [9:0] frame;
    int         r;
    bus.address = 16'h0000; bus.data_in = 8'h00; bus.read_en = 1'b1;
    resetb = 1'b0;
    idle(2);
    resetb = 1'b1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_irq", irq_empty, 1'b1);
    probe(BASE + 16'd1, 8'h00, 1'b1, st, oe);
    chk("rst_status", st, 8'h02);
    chk("rst_oe", oe, 1'b1);

    // Single byte A5: frame {stop, 1010_0101, start} sent LSB first.
    step(BASE, 8'hA5, 1'b0);
    chk("a5_irq_busy", irq_empty, 1'b0);
    frame = 10'b1101001010;
    idle(1);
    for (int k = 0; k < 10 * CPB; k++) begin
      chk("a5_frame", tx, frame[k / CPB]);
      idle(1);
    end
    chk("a5_irq_done", irq_empty, 1'b1);

    // Overflow: {overflow,4'b0,busy,empty,full} -> full+busy+overflow = 8'h85.
    for (int i = 1; i <= 6; i++) step(BASE, 8'(i), 1'b0);
    probe(BASE + 16'd1, 8'h00, 1'b1, st, oe);
    chk("ovf_status", st, 8'h85);
    probe(BASE + 16'd1, 8'h00, 1'b1, st, oe);
    chk("ovf_cleared", st, 8'h05);
    drain(400);

    // Store lands on the STOP->START edge while one byte is queued.
    x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
    step(BASE, x, 1'b0);
    step(BASE, y, 1'b0);
    idle(10 * CPB - 1);
    step(BASE, z, 1'b0);
    chk("pushpop_start", tx, 1'b0);
    probe(BASE + 16'd1, 8'h00, 1'b1, st, oe);
    chk("pushpop_status", st, 8'h04);
    drain(400);

    // Decode: wrong-direction accesses do nothing and never drive the bus.
    probe(BASE + 16'd1, 8'h5A, 1'b0, st, oe);
    chk("dec_wr_status_oe", oe, 1'b0);
    probe(BASE, 8'h00, 1'b1, st, oe);
    chk("dec_rd_txdata_oe", oe, 1'b0);
    probe(BASE + 16'd2, 8'h00, 1'b1, st, oe);
    chk("dec_rd_f002_oe", oe, 1'b0);
    probe(BASE + 16'd1, 8'h00, 1'b1, st, oe);
    chk("dec_status", st, 8'h02);

    // Reset during DATA bit 3 of FF, with another byte queued behind it.
    step(BASE, 8'hFF, 1'b0);
    step(BASE, 8'h3C, 1'b0);
    idle(3 * CPB + 3);
    chk("mid_bit3", tx, 1'b1);
    resetb = 1'b0;
    idle(1);
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_irq", irq_empty, 1'b1);
    resetb = 1'b1;
    probe(BASE + 16'd1, 8'h00, 1'b1, st, oe);
    chk("mid_status", st, 8'h02);

    // Reset during the start bit must force the line high.
    step(BASE, 8'h00, 1'b0);
    idle(2);
    chk("start_low", tx, 1'b0);
    resetb = 1'b0;
    idle(1);
    chk("start_rst_tx", tx, 1'b1);
    resetb = 1'b1;
    idle(1);

    // Random traffic: stores outpace the line, so overflow recurs.
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      step(BASE, 8'($urandom), 1'b0);
      else if (r < 16) step(BASE + 16'd1, 8'($urandom), 1'b0);
      else if (r < 24) step(BASE + 16'd1, 8'h00, 1'b1);
      else if (r < 26) step(BASE, 8'h00, 1'b1);
      else if (r < 28) step(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      else             idle(1);
    end
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
